// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, empty flag and level,
// plus a one-entry registered output stage with a valid/ready handshake.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   r_ptr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  r_empty,
  output logic [ADDR_WIDTH:0]   r_level,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int PW = ADDR_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         r_bin_q, r_bin_d;
  logic [PW-1:0]         r_ptr_q, r_gray_d;
  logic [PW-1:0]         r_level_q, r_level_d;
  logic                  r_empty_q, r_empty_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PW-1:0]         wptr_bin;
  logic                  pop;

  // Each binary bit is the XOR of all gray bits at and above it.
  for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
    assign wptr_bin[gi] = ^(rq2_wptr >> gi);
  end

  assign pop = !r_empty_q && (state_q == IDLE || out_ready);

  always_comb begin
    r_bin_d = r_bin_q;
    if (pop) begin
      r_bin_d = r_bin_q + PW'(1);
    end
    r_gray_d   = r_bin_d ^ (r_bin_d >> 1);
    r_empty_d  = (r_gray_d == rq2_wptr);
    r_level_d  = wptr_bin - r_bin_d;
    out_data_d = pop ? mem_rdata : out_data_q;
  end

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = HOLD;
      HOLD:    if (!pop && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
  end

  // r_ptr must come straight from a flop: it crosses into the write domain.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_bin_q    <= '0;
      r_ptr_q    <= '0;
      r_empty_q  <= 1'b1;
      r_level_q  <= '0;
      out_data_q <= '0;
    end else begin
      r_bin_q    <= r_bin_d;
      r_ptr_q    <= r_gray_d;
      r_empty_q  <= r_empty_d;
      r_level_q  <= r_level_d;
      out_data_q <= out_data_d;
    end
  end

  assign r_ptr    = r_ptr_q;
  assign r_addr   = r_bin_q[ADDR_WIDTH-1:0];
  assign r_empty  = r_empty_q;
  assign r_level  = r_level_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus a randomized stream, all checked
// against a count-based model of writer/reader progress.
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int PW = AW + 1;
  localparam int DEPTH = 16;

  logic          r_clk = 1'b0;
  logic          r_rst_n = 1'b0;
  logic [PW-1:0] rq2_wptr = '0;
  logic [PW-1:0] r_ptr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] mem_rdata;
  logic          r_empty;
  logic [PW-1:0] r_level;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  logic [DW-1:0] mem [DEPTH];

  int total = 0;
  int bad = 0;

  // Model: words written, words popped, and the output stage contents.
  int            wr_cnt;
  int            m_rd;
  int            m_level;
  bit            m_empty;
  bit            m_valid;
  logic [DW-1:0] m_data;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .r_clk(r_clk), .r_rst_n(r_rst_n), .rq2_wptr(rq2_wptr), .r_ptr(r_ptr),
    .r_addr(r_addr), .mem_rdata(mem_rdata), .r_empty(r_empty), .r_level(r_level),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  assign mem_rdata = mem[r_addr];

  always #5 r_clk = ~r_clk;

  function automatic logic [PW-1:0] to_gray(input int n);
    logic [PW-1:0] b;
    b = n[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    wr_cnt = 0; m_rd = 0; m_level = 0;
    m_empty = 1'b1; m_valid = 1'b0; m_data = '0;
    rq2_wptr = '0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wr_cnt % DEPTH] = d;
    wr_cnt++;
    rq2_wptr = to_gray(wr_cnt);
  endtask

  // Advance one edge; the model consumes the inputs present at that edge.
  task automatic tick();
    bit pop;
    @(posedge r_clk);
    pop = !m_empty && (!m_valid || out_ready);
    if (pop) begin
      m_data = mem[m_rd % DEPTH];
      m_valid = 1'b1;
      m_rd++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    m_empty = (m_rd == wr_cnt);
    m_level = wr_cnt - m_rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    r_rst_n = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge r_clk);
    @(negedge r_clk);
    r_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    r_rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rq2_wptr = PW'($urandom);
      out_ready = 1'($urandom);
      for (int j = 0; j < DEPTH; j++) mem[j] = DW'($urandom);
      @(posedge r_clk);
      #1;
    end
    total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got=%0h want=1", r_empty); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%0h want=0", out_valid); end
    total++; if (r_ptr !== 5'b00000) begin bad++; $display("FAIL reset_ptr: got=%05b want=00000", r_ptr); end
    total++; if (r_level !== 5'd0) begin bad++; $display("FAIL reset_level: got=%0d want=0", r_level); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got=%02h want=00", out_data); end
    total++; if (r_addr !== 4'd0) begin bad++; $display("FAIL reset_addr: got=%0d want=0", r_addr); end
    @(negedge r_clk);
    model_reset();
    out_ready = 1'($urandom);
    r_rst_n = 1'b1;
    repeat (3) tick();
    total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL release_empty: got=%0h want=1", r_empty); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_valid: got=%0h want=0", out_valid); end
    total++; if (r_ptr !== 5'b00000) begin bad++; $display("FAIL release_ptr: got=%05b want=00000", r_ptr); end
    total++; if (r_level !== 5'd0) begin bad++; $display("FAIL release_level: got=%0d want=0", r_level); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL release_data: got=%02h want=00", out_data); end
    $display("reset: checked during and after reset");
  endtask

  task automatic test_single_word();
    out_ready = 1'b1;
    push_word(8'hA5);
    tick();
    total++; if (r_empty !== 1'b0) begin bad++; $display("FAIL single_t1_empty: got=%0h want=0", r_empty); end
    total++; if (r_level !== 5'd1) begin bad++; $display("FAIL single_t1_level: got=%0d want=1", r_level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid: got=%0h want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_t2_valid: got=%0h want=1", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_t2_data: got=%02h want=a5", out_data); end
    total++; if (r_ptr !== 5'b00001) begin bad++; $display("FAIL single_t2_ptr: got=%05b want=00001", r_ptr); end
    total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL single_t2_empty: got=%0h want=1", r_empty); end
    total++; if (r_addr !== 4'd1) begin bad++; $display("FAIL single_t2_addr: got=%0d want=1", r_addr); end
    $display("xfer single data=%02h", out_data);
    tick();
    total++; if (r_level !== 5'd0) begin bad++; $display("FAIL single_t3_level: got=%0d want=0", r_level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t3_valid: got=%0h want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_bp [3];
    exp_bp[0] = 8'h11; exp_bp[1] = 8'h22; exp_bp[2] = 8'h33;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(exp_bp[i]);
    repeat (5) tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid: got=%0h want=1", out_valid); end
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL bp_hold_data: got=%02h want=11", out_data); end
    total++; if (r_level !== 5'd2) begin bad++; $display("FAIL bp_hold_level: got=%0d want=2", r_level); end
    total++; if (r_ptr !== 5'b00001) begin bad++; $display("FAIL bp_hold_ptr: got=%05b want=00001", r_ptr); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_bp[k]) begin
        bad++; $display("FAIL bp_word%0d: got valid=%0h data=%02h want valid=1 data=%02h", k, out_valid, out_data, exp_bp[k]);
      end
      $display("xfer bp%0d data=%02h", k, out_data);
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid: got=%0h want=0", out_valid); end
    total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL bp_drain_empty: got=%0h want=1", r_empty); end
    total++; if (r_ptr !== 5'b00010) begin bad++; $display("FAIL bp_drain_ptr: got=%05b want=00010", r_ptr); end
  endtask

  task automatic test_full_depth();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) push_word(DW'(i));
    tick();
    total++; if (r_level !== 5'b10000) begin bad++; $display("FAIL full_peak_level: got=%05b want=10000", r_level); end
    total++; if (r_empty !== 1'b0) begin bad++; $display("FAIL full_peak_empty: got=%0h want=0", r_empty); end
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== DW'(k) || r_level !== PW'(m_level)) begin
        bad++; $display("FAIL full_word%0d: got valid=%0h data=%02h level=%0d want valid=1 data=%02h level=%0d",
                        k, out_valid, out_data, r_level, k, m_level);
      end
      $display("xfer full%0d data=%02h", k, out_data);
    end
    total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL full_end_empty: got=%0h want=1", r_empty); end
  endtask

  task automatic test_wrap_random();
    logic [DW-1:0] expq [$];
    logic [DW-1:0] d;
    logic [PW-1:0] prev_ptr;
    logic [AW-1:0] prev_addr;
    int sent, got, wraps, cyc;
    bit seen_roll;
    sent = 0; got = 0; wraps = 0; seen_roll = 1'b0;
    tick();
    prev_ptr = r_ptr;
    prev_addr = r_addr;
    for (cyc = 0; cyc < 3000 && got < 40; cyc++) begin
      if (sent < 40 && (wr_cnt - m_rd) <= 6 && $urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 10; j++) begin
          d = DW'($urandom);
          expq.push_back(d);
          push_word(d);
          sent++;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++; $display("FAIL wrap_extra_word: got data=%02h want no word", out_data);
        end else begin
          d = expq.pop_front();
          if (out_data !== d) begin bad++; $display("FAIL wrap_word%0d: got=%02h want=%02h", got, out_data, d); end
        end
        $display("xfer wrap%0d data=%02h", got, out_data);
        got++;
      end
      tick();
      total++;
      if (r_ptr !== to_gray(m_rd) || r_level !== PW'(m_level) || r_empty !== m_empty ||
          out_valid !== m_valid || r_addr !== AW'(m_rd % DEPTH) || (m_valid && out_data !== m_data)) begin
        bad++; $display("FAIL wrap_state cyc%0d: got ptr=%05b lvl=%0d emp=%0h val=%0h addr=%0d data=%02h want ptr=%05b lvl=%0d emp=%0h val=%0h addr=%0d data=%02h",
                        cyc, r_ptr, r_level, r_empty, out_valid, r_addr, out_data,
                        to_gray(m_rd), m_level, m_empty, m_valid, m_rd % DEPTH, m_data);
      end
      if (prev_ptr == 5'b10000 && r_ptr == 5'b00000) seen_roll = 1'b1;
      if (prev_addr == 4'd15 && r_addr == 4'd0) wraps++;
      prev_ptr = r_ptr;
      prev_addr = r_addr;
    end
    total++; if (got != 40) begin bad++; $display("FAIL wrap_count: got=%0d want=40", got); end
    total++; if (!seen_roll) begin bad++; $display("FAIL wrap_ptr_roll: got=0 want=1 (10000 then 00000)"); end
    total++; if (wraps < 2) begin bad++; $display("FAIL wrap_addr: got=%0d want>=2", wraps); end
  endtask

  task automatic test_reset_mid_stream();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(DW'(8'hC0 + i));
    tick();
    tick();
    total++; if (out_valid !== 1'b1 || r_level !== 5'd5) begin
      bad++; $display("FAIL mid_pre: got valid=%0h level=%0d want valid=1 level=5", out_valid, r_level);
    end
    #3;
    r_rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got=%0h want=0", out_valid); end
    total++; if (r_level !== 5'd0) begin bad++; $display("FAIL mid_level: got=%0d want=0", r_level); end
    total++; if (r_ptr !== 5'b00000) begin bad++; $display("FAIL mid_ptr: got=%05b want=00000", r_ptr); end
    total++; if (r_empty !== 1'b1) begin bad++; $display("FAIL mid_empty: got=%0h want=1", r_empty); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL mid_data: got=%02h want=00", out_data); end
    model_reset();
    @(negedge r_clk);
    r_rst_n = 1'b1;
    tick();
    total++; if (r_empty !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_after: got empty=%0h valid=%0h want empty=1 valid=0", r_empty, out_valid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_word();
    test_backpressure();
    test_full_depth();
    test_wrap_random();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
